instr_fetch_decode: RTL and testbench
=====================================

Name: instr_fetch_decode

Overview:
- Control stage wrapped around the program counter block.
- Reads the current PC count, fetches a 16-bit instruction from program memory and latches it into an instruction register (IR).
- Decodes the IR, then either issues the instruction to the execute stage or drives the PC control inputs (A, B, SelPC, IncPC, LoadPC) to advance or redirect the PC.
- Sole producer of all PC control inputs.

Parameters:
- ADDR_W, 8, PC/instruction-memory address width; equals the PC count width.
- OFS_W, 4, relative-branch offset width; equals the PC B input width.
- TIMEOUT_CYC, 16, fetch watchdog limit in cycles (used only when IFD_TIMEOUT_EN is defined).

Ports:
- CLK  in  1  rising-edge clock.
- CLB  in  1  asynchronous active-low reset.
- pc_count  in  ADDR_W  current PC value from the PC stage.
- imem_req  out  1  fetch request to program memory.
- imem_addr  out  ADDR_W  fetch address; equals pc_count while imem_req=1, else 0.
- imem_valid  in  1  instruction data valid.
- imem_data  in  16  instruction word: [15:12] opcode, [11:8] offset, [7:0] operand.
- A  out  ADDR_W  absolute load value to the PC.
- B  out  OFS_W  relative offset to the PC.
- SelPC  out  1  PC load source: 0 = A (absolute), 1 = pc_count+B (relative).
- IncPC  out  1  one-cycle pulse, PC <= PC+1.
- LoadPC  out  1  one-cycle pulse, PC <= selected source.
- flag_z  in  1  zero flag from the execute stage, used by BZ.
- ex_valid  out  1  instruction offered to the execute stage.
- ex_ready  in  1  execute stage accepts.
- ex_op  out  4  issued opcode.
- ex_operand  out  8  issued operand.
- run  in  1  restart from HALT.
- halted  out  1  high in HALT.
- fault  out  1  fetch timeout flag (sticky until reset).

Behaviour:
- Reset (CLB=0, asynchronous): state=FETCH.
  - IR=0; all outputs 0: imem_req, A, B, SelPC, IncPC, LoadPC, ex_valid, ex_op, ex_operand, halted, fault.
  - Any memory response in flight is discarded.
- FETCH:
  - imem_req=1; imem_addr=pc_count.
  - Holds until imem_valid=1; on that edge IR<=imem_data, go to DECODE.
  - imem_valid while imem_req=0 is ignored.
- DECODE (1 cycle): opcode selects the next state.
  - 0 NOP -> STEP.
  - 1 JMP -> BRANCH, SelPC=0, A=IR[7:0].
  - 2 JR -> BRANCH, SelPC=1, B=IR[11:8].
  - 3 BZ -> BRANCH (as JMP) if flag_z=1 sampled in DECODE, else STEP.
  - 4 HLT -> HALT.
  - 5..15 -> ISSUE.
- ISSUE:
  - ex_valid=1, ex_op=IR[15:12], ex_operand=IR[7:0], all held stable until ex_valid&&ex_ready.
  - On the accepting edge -> STEP.
  - ex_ready while ex_valid=0 is ignored.
- STEP (1 cycle): IncPC=1 -> FETCH.
- BRANCH (1 cycle): LoadPC=1; A/B/SelPC held from DECODE -> FETCH.
- PC timing: the PC updates on the edge ending STEP/BRANCH. The next FETCH sees the updated pc_count.
- Pulse rules:
  - IncPC and LoadPC are never both high.
  - Each is exactly one cycle per instruction.
  - A/B/SelPC keep their last value outside BRANCH.
- HALT:
  - halted=1; no requests, no pulses.
  - run=1 sampled in HALT -> STEP; the PC advances past HLT.
  - run outside HALT is ignored.
- Throughput with imem_valid in the same cycle as the request:
  - NOP/branch: 3 cycles per instruction.
  - ISSUE with ex_ready=1: 4 cycles per instruction.
- Wrap: PC arithmetic wraps modulo 2^ADDR_W and belongs to the PC stage; this block performs no address arithmetic.

Optional Feature:
- IFD_TIMEOUT_EN defined:
  - 5-bit wait counter in FETCH, cleared on entry.
  - If imem_valid is not seen within TIMEOUT_CYC cycles -> HALT with fault=1.
  - run clears halted but not fault.
- Not defined: FETCH waits indefinitely; fault is tied 0.

Test Plan:
- Reset then release, memory returns NOP (0x0000) immediately -> IncPC pulses every 3rd cycle; imem_addr follows pc_count 0,1,2.
- Fetch JMP 0x1021 -> LoadPC one cycle, SelPC=0, A=0x21, IncPC=0; next imem_addr=0x21.
- JR 0x2E00 at PC=0x10 -> LoadPC=1, SelPC=1, B=0xE; BZ 0x3055 with flag_z=0 -> IncPC only; with flag_z=1 -> LoadPC with A=0x55.
- ALU op 0x7A3C with ex_ready low 4 cycles -> ex_valid held, ex_op=7, ex_operand=0x3C stable; IncPC only after acceptance.
- HLT 0x4000 -> halted=1, no imem_req; run pulse -> IncPC, fetch resumes. Assert CLB low during ISSUE -> ex_valid=0 immediately; restart in FETCH.
- With IFD_TIMEOUT_EN, imem_valid held 0 -> fault=1, halted=1 after 16 cycles; without the macro -> imem_req stays high, fault=0.

Source files
------------

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: fetch/decode control stage wrapped around the PC block.
// Fetches a 16-bit instruction at pc_count, latches it into IR, decodes it
// and then issues it to execute, halts, or pulses IncPC/LoadPC.
// It is the only source of the PC control inputs A, B, SelPC, IncPC and LoadPC.
//
// Optional build macro IFD_TIMEOUT_EN: enables a fetch watchdog. If no
// imem_valid arrives within TIMEOUT_CYC cycles of FETCH, the block enters
// HALT and sets the sticky fault flag. Without the macro, FETCH waits forever
// and fault is tied to 0.
//
// Handshakes: imem and execute use valid/ready semantics. A request (imem_req
// or ex_valid) stays high, with its payload stable, until the edge on which
// the partner's valid/ready is sampled high. That edge completes the
// transfer. A partner strobe seen while our side is low is ignored.
module instr_fetch_decode #(
  parameter int ADDR_W      = 8,
  parameter int OFS_W       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              CLK,
  input  logic              CLB,
  input  logic [ADDR_W-1:0] pc_count,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_data,
  output logic [ADDR_W-1:0] A,
  output logic [OFS_W-1:0]  B,
  output logic              SelPC,
  output logic              IncPC,
  output logic              LoadPC,
  input  logic              flag_z,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [3:0]        ex_op,
  output logic [7:0]        ex_operand,
  input  logic              run,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_ISSUE  = 3'd2,
    S_STEP   = 3'd3,
    S_BRANCH = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_JMP = 4'd1;
  localparam logic [3:0] OP_JR  = 4'd2;
  localparam logic [3:0] OP_BZ  = 4'd3;
  localparam logic [3:0] OP_HLT = 4'd4;

  // state_q is the FSM state, kept under a stable name for hierarchical probes.
  state_t              state_q, state_d;
  logic [15:0]         ir_q;
  logic                ir_load;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [OFS_W-1:0]    b_q, b_d;
  logic                sel_q, sel_d;
  logic                fault_q, fault_d;
  logic [3:0]          opcode;

  assign opcode = ir_q[15:12];

`ifdef IFD_TIMEOUT_EN
  logic [4:0] wait_q;

  // Fetch wait counter: runs only in FETCH. Leaving FETCH clears it, so it starts at 0 on every entry.
  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      wait_q <= '0;
    end else if (state_q != S_FETCH) begin
      wait_q <= '0;
    end else if (!imem_valid) begin
      wait_q <= wait_q + 5'd1;
    end
  end
`endif

  // State, instruction register and held PC-control registers.
  always_ff @(posedge CLK or negedge CLB) begin
    if (!CLB) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      fault_q <= fault_d;
      if (ir_load) begin
        ir_q <= imem_data;
      end
    end
  end

  // Next-state decode. Branch targets are captured in DECODE so they are stable through BRANCH.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    fault_d = fault_q;
    ir_load = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
`ifdef IFD_TIMEOUT_EN
        else if (wait_q == 5'(TIMEOUT_CYC - 1)) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end
`endif
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP: state_d = S_STEP;
          OP_JMP: begin
            state_d = S_BRANCH;
            sel_d   = 1'b0;
            a_d     = ADDR_W'(ir_q[7:0]);
          end
          OP_JR: begin
            state_d = S_BRANCH;
            sel_d   = 1'b1;
            b_d     = OFS_W'(ir_q[11:8]);
          end
          OP_BZ: begin
            if (flag_z) begin
              state_d = S_BRANCH;
              sel_d   = 1'b0;
              a_d     = ADDR_W'(ir_q[7:0]);
            end else begin
              state_d = S_STEP;
            end
          end
          OP_HLT:  state_d = S_HALT;
          default: state_d = S_ISSUE;
        endcase
      end
      S_ISSUE: begin
        if (ex_ready) begin
          state_d = S_STEP;
        end
      end
      S_STEP:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_HALT: begin
        if (run) begin
          state_d = S_STEP;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Moore outputs. imem_req is also gated by CLB so that no request is seen while reset is held.
  always_comb begin
    imem_req   = (state_q == S_FETCH) && CLB;
    imem_addr  = imem_req ? pc_count : '0;
    IncPC      = (state_q == S_STEP);
    LoadPC     = (state_q == S_BRANCH);
    ex_valid   = (state_q == S_ISSUE);
    ex_op      = ex_valid ? ir_q[15:12] : 4'd0;
    ex_operand = ex_valid ? ir_q[7:0]   : 8'd0;
    halted     = (state_q == S_HALT);
    A          = a_q;
    B          = b_q;
    SelPC      = sel_q;
    fault      = fault_q;
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode. It models the PC stage and program memory.
// Directed instructions push their expected events into exp_q. A negedge
// monitor pops one entry for every event the DUT shows and compares it.
module tb_instr_fetch_decode;

  localparam int ADDR_W = 8;
  localparam int OFS_W  = 4;

  logic              clk = 1'b0;
  logic              clb;
  logic [ADDR_W-1:0] pc_count;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [15:0]       imem_data;
  logic [ADDR_W-1:0] A;
  logic [OFS_W-1:0]  B;
  logic              SelPC, IncPC, LoadPC;
  logic              flag_z;
  logic              ex_valid, ex_ready;
  logic [3:0]        ex_op;
  logic [7:0]        ex_operand;
  logic              run, halted, fault;

  logic [19:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int last_inc = 0;
  int prev_inc = 0;
  logic halted_prev = 1'b0;

  instr_fetch_decode #(.ADDR_W(ADDR_W), .OFS_W(OFS_W), .TIMEOUT_CYC(16)) dut (
    .CLK(clk), .CLB(clb), .pc_count(pc_count), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .A(A), .B(B), .SelPC(SelPC), .IncPC(IncPC), .LoadPC(LoadPC),
    .flag_z(flag_z), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_operand(ex_operand), .run(run), .halted(halted), .fault(fault)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // PC stage model: relative loads add B zero-extended and wrap modulo 2^ADDR_W
  always @(posedge clk or negedge clb) begin
    if (!clb) pc_count <= '0;
    else if (IncPC) pc_count <= pc_count + 8'd1;
    else if (LoadPC) pc_count <= SelPC ? (pc_count + {4'd0, B}) : A;
  end

  // event encodings: {kind, payload}
  function automatic logic [19:0] ev_inc();
    return {4'd1, 16'h0};
  endfunction
  function automatic logic [19:0] ev_load(input logic s, input logic [3:0] b, input logic [7:0] a);
    return {4'd2, 3'b0, s, b, a};
  endfunction
  function automatic logic [19:0] ev_issue(input logic [3:0] op, input logic [7:0] opd);
    return {4'd3, 4'h0, op, opd};
  endfunction
  function automatic logic [19:0] ev_fetch(input logic [7:0] addr);
    return {4'd4, 8'h0, addr};
  endfunction
  function automatic logic [19:0] ev_halt();
    return {4'd5, 16'h0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act === exp) passes = passes + 1;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic log_ev(input logic [19:0] act);
    logic [19:0] e;
    if (exp_q.size() == 0) begin
      checks = checks + 1;
      $display("FAIL unexpected_event actual=%h required=none", act);
    end else begin
      e = exp_q.pop_front();
      chk("event", {12'h0, act}, {12'h0, e});
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (clb) begin
      if (IncPC || LoadPC) chk("pulse_excl", {31'h0, IncPC & LoadPC}, 32'h0);
      if (imem_req && imem_valid) log_ev(ev_fetch(imem_addr));
      if (IncPC) begin
        log_ev(ev_inc());
        prev_inc = last_inc;
        last_inc = cyc;
      end
      if (LoadPC) log_ev(ev_load(SelPC, B, A));
      if (ex_valid && ex_ready) log_ev(ev_issue(ex_op, ex_operand));
      if (halted && !halted_prev) log_ev(ev_halt());
    end
    halted_prev = halted;
  end

  // driver: wait (bounded) for a request, optionally stall, then return one word
  task automatic serve(input logic [15:0] instr, input int delay);
    int n;
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      if (imem_req) break;
      n = n + 1;
      if (n > 50) begin
        checks = checks + 1;
        $display("FAIL fetch_wait actual=no_request required=request");
        return;
      end
    end
    repeat (delay) begin @(posedge clk); #1; end
    imem_valid = 1'b1;
    imem_data  = instr;
    @(posedge clk); #1;
    imem_valid = 1'b0;
    imem_data  = 16'h0;
  endtask

  task automatic step_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    clb = 1'b0; imem_valid = 1'b0; imem_data = 16'h0;
    flag_z = 1'b0; ex_ready = 1'b0; run = 1'b0;
    #12;
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_pulses", {30'h0, IncPC, LoadPC}, 32'h0);
    chk("rst_ex", {19'h0, ex_valid, ex_op, ex_operand}, 32'h0);
    chk("rst_pcctl", {19'h0, SelPC, B, A}, 32'h0);
    chk("rst_flags", {30'h0, halted, fault}, 32'h0);

    @(posedge clk); #1;
    clb = 1'b1;

    // three NOPs back-to-back
    exp_q.push_back(ev_fetch(8'h00)); exp_q.push_back(ev_inc());
    exp_q.push_back(ev_fetch(8'h01)); exp_q.push_back(ev_inc());
    exp_q.push_back(ev_fetch(8'h02)); exp_q.push_back(ev_inc());
    serve(16'h0000, 0);
    serve(16'h0000, 0);
    serve(16'h0000, 0);
    step_cyc(2);
    chk("nop_period", last_inc - prev_inc, 32'd3);

    // JMP 0x21, then JMP 0x10
    exp_q.push_back(ev_fetch(8'h03)); exp_q.push_back(ev_load(1'b0, 4'h0, 8'h21));
    serve(16'h1021, 0);
    exp_q.push_back(ev_fetch(8'h21)); exp_q.push_back(ev_load(1'b0, 4'h0, 8'h10));
    serve(16'h1010, 2);

    // JR +0xE at PC 0x10 -> 0x1E
    exp_q.push_back(ev_fetch(8'h10)); exp_q.push_back(ev_load(1'b1, 4'hE, 8'h10));
    serve(16'h2E00, 0);

    // BZ not taken, then taken
    flag_z = 1'b0;
    exp_q.push_back(ev_fetch(8'h1E)); exp_q.push_back(ev_inc());
    serve(16'h3055, 0);
    step_cyc(1);
    flag_z = 1'b1;
    exp_q.push_back(ev_fetch(8'h1F)); exp_q.push_back(ev_load(1'b0, 4'hE, 8'h55));
    serve(16'h3055, 0);
    step_cyc(1);
    flag_z = 1'b0;

    // ALU op with execute stalled for four cycles
    ex_ready = 1'b0;
    exp_q.push_back(ev_fetch(8'h55)); exp_q.push_back(ev_issue(4'h7, 8'h3C));
    exp_q.push_back(ev_inc());
    serve(16'h7A3C, 0);
    step_cyc(1);
    for (int i = 0; i < 4; i++) begin
      chk("stall_hold", {19'h0, ex_valid, ex_op, ex_operand}, {19'h0, 1'b1, 4'h7, 8'h3C});
      step_cyc(1);
    end
    ex_ready = 1'b1;

    // ALU op accepted at once: 4-cycle instruction
    exp_q.push_back(ev_fetch(8'h56)); exp_q.push_back(ev_issue(4'hF, 8'hFF));
    exp_q.push_back(ev_inc());
    serve(16'hF0FF, 0);
    step_cyc(3);
    chk("issue_period", last_inc - prev_inc, 32'd4);

    // HLT, then resume with run
    exp_q.push_back(ev_fetch(8'h57)); exp_q.push_back(ev_halt());
    serve(16'h4000, 0);
    step_cyc(1);
    for (int i = 0; i < 3; i++) begin
      chk("halt_state", {30'h0, halted, imem_req}, {30'h0, 2'b10});
      step_cyc(1);
    end
    exp_q.push_back(ev_inc()); exp_q.push_back(ev_fetch(8'h58));
    run = 1'b1;
    step_cyc(1);
    run = 1'b0;

    // ALU op stalled, run pulsed (ignored), then reset mid-ISSUE
    ex_ready = 1'b0;
    serve(16'h5123, 0);
    step_cyc(1);
    chk("issue_pre_reset", {23'h0, ex_valid, ex_op, ex_operand}, {23'h0, 1'b1, 4'h5, 8'h23});
    run = 1'b1;
    step_cyc(1);
    run = 1'b0;
    chk("run_ignored", {31'h0, ex_valid}, 32'h1);
    #2 clb = 1'b0;
    #1;
    chk("reset_ex_valid", {31'h0, ex_valid}, 32'h0);
    chk("reset_outputs", {16'h0, imem_req, IncPC, LoadPC, halted, SelPC, B, A[6:0]}, 32'h0);
    @(posedge clk); #1;
    clb = 1'b1;
    #1;
    chk("restart_fetch", {23'h0, imem_req, imem_addr}, {23'h0, 1'b1, 8'h00});

    // no memory response for 20 cycles
`ifdef IFD_TIMEOUT_EN
    exp_q.push_back(ev_halt());
    step_cyc(20);
    chk("timeout_flags", {29'h0, halted, fault, imem_req}, {29'h0, 3'b110});
    exp_q.push_back(ev_inc());
    run = 1'b1;
    step_cyc(1);
    run = 1'b0;
    step_cyc(1);
    chk("fault_sticky", {30'h0, halted, fault}, {30'h0, 2'b01});
    exp_q.push_back(ev_fetch(8'h01)); exp_q.push_back(ev_inc());
`else
    step_cyc(20);
    chk("wait_forever", {29'h0, halted, fault, imem_req}, {29'h0, 3'b001});
    exp_q.push_back(ev_fetch(8'h00)); exp_q.push_back(ev_inc());
`endif
    serve(16'h0000, 0);
    step_cyc(4);
    chk("queue_drain", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
